// File: rtl/vga_display_core.sv
// -----------------------------------------------------------------------------
// vga_display_core
//
// VGA timing generator and pixel output stage with configurable geometry,
// pixel-clock divide, colour width and number of colour sources.
//
// A clock divider produces a one-clk pixel enable (pix_tick). The horizontal
// and vertical counters step on that enable. The counters are exported as the
// pixel coordinates so that the colour sources can present the colour for
// (pix_x, pix_y) in the same pixel period. One of NUM_SRC sources is selected.
// The selection is re-latched only at the frame wrap, so a frame never mixes
// two sources. RGB and both syncs are registered on the pixel tick and keep
// the same one-tick latency, so colour and sync stay aligned at the pins.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   src_sel      in   requested source index (latched at frame wrap)
//   src_rgb      in   packed source colours, source k at [k*RGB_W +: RGB_W]
//   pix_tick     out  pixel-clock enable, one clk wide
//   pix_x        out  horizontal count
//   pix_y        out  vertical count
//   video_on     out  current (pix_x, pix_y) lies in the active area
//   frame_start  out  high on the tick where the counters wrap to (0,0)
//   h_sync       out  registered horizontal sync, SYNC_POL polarity
//   v_sync       out  registered vertical sync, SYNC_POL polarity
//   RGB          out  registered pixel colour
// -----------------------------------------------------------------------------
module vga_display_core #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int NUM_SRC  = 2,
  parameter int RGB_W    = 3,
  parameter int XY_W     = 10,
  parameter int SYNC_POL = 0,
  parameter int SEL_W    = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SEL_W-1:0]           src_sel,
  input  logic [NUM_SRC*RGB_W-1:0]   src_rgb,
  output logic                       pix_tick,
  output logic [XY_W-1:0]            pix_x,
  output logic [XY_W-1:0]            pix_y,
  output logic                       video_on,
  output logic                       frame_start,
  output logic                       h_sync,
  output logic                       v_sync,
  output logic [RGB_W-1:0]           RGB
);

  // ---------------------------------------------------------------------------
  // Derived geometry
  // ---------------------------------------------------------------------------
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A divide-by-one still keeps a one-bit counter; it simply never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_TOTAL - 1);
  localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_TOTAL - 1);
  localparam logic [XY_W-1:0] H_VIS    = XY_W'(H_ACTIVE);
  localparam logic [XY_W-1:0] V_VIS    = XY_W'(V_ACTIVE);
  localparam logic [XY_W-1:0] HS_FIRST = XY_W'(H_ACTIVE + H_FP);
  localparam logic [XY_W-1:0] HS_LAST  = XY_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [XY_W-1:0] VS_FIRST = XY_W'(V_ACTIVE + V_FP);
  localparam logic [XY_W-1:0] VS_LAST  = XY_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = (SYNC_POL != 0) ? 1'b0 : 1'b1;

  // ---------------------------------------------------------------------------
  // State and next-state
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [XY_W-1:0]  h_q, h_d;
  logic [XY_W-1:0]  v_q, v_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             sel_inv_q, sel_inv_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;

  // Combinational decodes
  logic             tick_s;
  logic             h_last_s;
  logic             v_last_s;
  logic             video_s;
  logic             frame_s;
  logic             hs_win_s;
  logic             vs_win_s;
  logic             sel_ok_s;
  logic [RGB_W-1:0] src_pix_s;

  // ---------------------------------------------------------------------------
  // Decodes from the current counter state
  // ---------------------------------------------------------------------------
  assign tick_s   = (div_q == DIV_LAST);
  assign h_last_s = (h_q == H_LAST);
  assign v_last_s = (v_q == V_LAST);
  assign video_s  = (h_q < H_VIS) && (v_q < V_VIS);
  assign frame_s  = tick_s && h_last_s && v_last_s;
  assign hs_win_s = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
  assign vs_win_s = (v_q >= VS_FIRST) && (v_q <= VS_LAST);

  // A request outside the implemented sources blanks the whole next frame.
  assign sel_ok_s = (32'(src_sel) < 32'(NUM_SRC));

  // Pixel divider: free-running modulo-CLK_DIV count, cleared on the tick.
  always_comb begin
    div_d = div_q;
    if (tick_s) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  // Raster counters: h wraps every line and carries into v, which wraps per frame.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick_s) begin
      if (h_last_s) begin
        h_d = '0;
        if (v_last_s) begin
          v_d = '0;
        end else begin
          v_d = v_q + XY_W'(1);
        end
      end else begin
        h_d = h_q + XY_W'(1);
        v_d = v_q;
      end
    end else begin
      h_d = h_q;
      v_d = v_q;
    end
  end

  // Source latch: re-evaluated only on the frame wrap to avoid tearing.
  always_comb begin
    sel_d     = sel_q;
    sel_inv_d = sel_inv_q;
    if (frame_s) begin
      if (sel_ok_s) begin
        sel_d     = src_sel;
        sel_inv_d = 1'b0;
      end else begin
        sel_d     = '0;
        sel_inv_d = 1'b1;
      end
    end else begin
      sel_d     = sel_q;
      sel_inv_d = sel_inv_q;
    end
  end

  // Colour mux over the latched source; a loop keeps out-of-range codes at 0.
  always_comb begin
    src_pix_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) begin
        src_pix_s = src_rgb[k*RGB_W +: RGB_W];
      end else begin
        src_pix_s = src_pix_s;
      end
    end
  end

  // Output stage: colour and syncs for the current coordinate, loaded on the tick.
  always_comb begin
    rgb_d = rgb_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    if (tick_s) begin
      rgb_d = (video_s && !sel_inv_q) ? src_pix_s : '0;
      hs_d  = hs_win_s ? SYNC_ON : SYNC_OFF;
      vs_d  = vs_win_s ? SYNC_ON : SYNC_OFF;
    end else begin
      rgb_d = rgb_q;
      hs_d  = hs_q;
      vs_d  = vs_q;
    end
  end

  // State registers with asynchronous reset to the idle raster position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q     <= '0;
      h_q       <= '0;
      v_q       <= '0;
      sel_q     <= '0;
      sel_inv_q <= 1'b0;
      rgb_q     <= '0;
      hs_q      <= SYNC_OFF;
      vs_q      <= SYNC_OFF;
    end else begin
      div_q     <= div_d;
      h_q       <= h_d;
      v_q       <= v_d;
      sel_q     <= sel_d;
      sel_inv_q <= sel_inv_d;
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pix_tick    = tick_s;
  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign video_on    = video_s;
  assign frame_start = frame_s;
  assign h_sync      = hs_q;
  assign v_sync      = vs_q;
  assign RGB         = rgb_q;

endmodule

// File: tb/tb_vga_display_core.sv
// -----------------------------------------------------------------------------
// tb_vga_display_core
//
// Three configurations of vga_display_core run side by side on one clock:
//   cfg0: default 800-pixel line, short frame (V 4/1/1/1), CLK_DIV=2, 2 sources
//   cfg1: small geometry, CLK_DIV=3, 3 sources on a 2-bit select (code 3 invalid)
//   cfg2: H 8/1/2/1, V 4/1/1/1, CLK_DIV=1, active-high syncs, reset mid-line
// Each configuration has a reference model that tracks elapsed clk edges and
// derives the raster position, syncs and colour arithmetically. It is checked
// on every negative clock edge while the inputs are randomised. Hand-computed
// expectations pin the line timing, reset release and frame length.
// -----------------------------------------------------------------------------
module tb_vga_display_core;

  logic       clk = 1'b0;
  logic [2:0] rst = 3'b111;

  int checks = 0;
  int errors = 0;

  logic [2:0]       tick_all;
  logic [2:0]       von_all;
  logic [2:0]       fs_all;
  logic [2:0]       hs_all;
  logic [2:0]       vs_all;
  logic [2:0][9:0]  px_all;
  logic [2:0][9:0]  py_all;
  logic [2:0][2:0]  rgb_all;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int cfg, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg%0d got %0d expected %0d at %0t", nm, cfg, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int HA  = (g == 0) ? 640 : (g == 1) ? 16 : 8;
    localparam int HF  = (g == 0) ? 16  : (g == 1) ? 2  : 1;
    localparam int HS  = (g == 0) ? 96  : (g == 1) ? 3  : 2;
    localparam int HB  = (g == 0) ? 48  : (g == 1) ? 3  : 1;
    localparam int VA  = (g == 1) ? 6 : 4;
    localparam int VF  = 1;
    localparam int VS  = (g == 1) ? 2 : 1;
    localparam int VB  = 1;
    localparam int CD  = (g == 0) ? 2 : (g == 1) ? 3 : 1;
    localparam int NS  = (g == 1) ? 3 : 2;
    localparam int SW  = (g == 1) ? 2 : 1;
    localparam int CHG = (g == 0) ? 3000 : (g == 1) ? 150 : 40;
    localparam logic SP = (g == 2) ? 1'b1 : 1'b0;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;

    logic [SW-1:0]   sel    = '0;
    logic [NS*3-1:0] rgb_in = '0;
    logic            tick, von, fs, hs, vs;
    logic [9:0]      px, py;
    logic [2:0]      rgb;

    vga_display_core #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(CD), .NUM_SRC(NS), .RGB_W(3), .XY_W(10),
      .SYNC_POL(int'(SP)), .SEL_W(SW)
    ) u_dut (
      .clk(clk), .reset(rst[g]), .src_sel(sel), .src_rgb(rgb_in),
      .pix_tick(tick), .pix_x(px), .pix_y(py), .video_on(von),
      .frame_start(fs), .h_sync(hs), .v_sync(vs), .RGB(rgb)
    );

    assign tick_all[g] = tick;
    assign von_all[g]  = von;
    assign fs_all[g]   = fs;
    assign hs_all[g]   = hs;
    assign vs_all[g]   = vs;
    assign px_all[g]   = px;
    assign py_all[g]   = py;
    assign rgb_all[g]  = rgb;

    // Reference model: m_c = clk edges since reset; m_sel = -1 means blanked frame.
    int         m_c   = 0;
    int         m_sel = 0;
    logic [2:0] m_rgb = 3'b000;
    logic       m_hs  = ~SP;
    logic       m_vs  = ~SP;
    int         mp, mx, my;
    logic       e_tick;

    assign e_tick = ((m_c % CD) == CD - 1);
    assign mp     = (m_c / CD) % (HT * VT);
    assign mx     = mp % HT;
    assign my     = mp / HT;

    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        m_c   <= 0;
        m_sel <= 0;
        m_rgb <= 3'b000;
        m_hs  <= ~SP;
        m_vs  <= ~SP;
      end else begin
        m_c <= m_c + 1;
        if (e_tick) begin
          m_rgb <= (mx < HA && my < VA && m_sel >= 0) ? 3'(rgb_in >> (3 * m_sel)) : 3'b000;
          m_hs  <= (mx >= HA + HF && mx < HA + HF + HS) ? SP : ~SP;
          m_vs  <= (my >= VA + VF && my < VA + VF + VS) ? SP : ~SP;
          if (mp == HT * VT - 1) m_sel <= (int'(sel) < NS) ? int'(sel) : -1;
        end
      end
    end

    // Compare every cycle, then drive fresh random inputs for the next edge.
    initial begin
      forever begin
        @(negedge clk);
        chk("pix_tick",    g, 32'(tick), 32'(e_tick));
        chk("pix_x",       g, 32'(px),   32'(mx));
        chk("pix_y",       g, 32'(py),   32'(my));
        chk("video_on",    g, 32'(von),  32'(mx < HA && my < VA));
        chk("frame_start", g, 32'(fs),   32'(e_tick && mp == HT * VT - 1));
        chk("rgb",         g, 32'(rgb),  32'(m_rgb));
        chk("h_sync",      g, 32'(hs),   32'(m_hs));
        chk("v_sync",      g, 32'(vs),   32'(m_vs));
        rgb_in = (NS*3)'($urandom);
        if (e_tick && mp == HT * VT - 1) begin
          sel = SW'($urandom_range(2**SW - 1, 0));
        end else if ($urandom_range(CHG, 0) == 0) begin
          sel = SW'($urandom_range(2**SW - 1, 0));
        end
      end
    end
  end

  // Directed timing pins and the mid-line reset of cfg2.
  initial begin
    int t;
    int first_low;
    int hs_low;
    int von_hi;
    int found;

    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 3'b000;
    #1;
    chk("rel_pix_tick", 0, 32'(tick_all[0]), 32'd0);
    chk("rel_pix_x",    0, 32'(px_all[0]),   32'd0);
    chk("rel_pix_y",    0, 32'(py_all[0]),   32'd0);
    chk("rel_rgb",      0, 32'(rgb_all[0]),  32'd0);
    chk("rel_h_sync",   0, 32'(hs_all[0]),   32'd1);
    chk("rel_v_sync",   0, 32'(vs_all[0]),   32'd1);

    von_hi    = von_all[0] ? 1 : 0;
    hs_low    = 0;
    first_low = -1;
    for (int e = 1; e <= 1600; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) begin
        chk("edge1_tick", 0, 32'(tick_all[0]), 32'd1);
        chk("edge1_x",    0, 32'(px_all[0]),   32'd0);
      end
      if (e == 2) begin
        chk("edge2_tick", 0, 32'(tick_all[0]), 32'd0);
        chk("edge2_x",    0, 32'(px_all[0]),   32'd1);
      end
      if (e % 2 == 0) begin
        t = e / 2;
        if (!hs_all[0]) begin
          hs_low++;
          if (first_low < 0) first_low = t;
        end
        if (t < 800 && von_all[0]) von_hi++;
        if (t == 800) begin
          chk("line_wrap_x", 0, 32'(px_all[0]), 32'd0);
          chk("line_wrap_y", 0, 32'(py_all[0]), 32'd1);
        end
      end
    end
    chk("hsync_first_low_tick", 0, 32'(first_low), 32'd657);
    chk("hsync_low_ticks",      0, 32'(hs_low),    32'd96);
    chk("video_on_ticks",       0, 32'(von_hi),    32'd640);

    // Reset cfg2 in the middle of a line, away from any clock edge.
    found = 0;
    for (int k = 0; k < 40 && found == 0; k++) begin
      @(negedge clk);
      if (px_all[2] == 10'd5) found = 1;
    end
    chk("c_reach_x5", 2, 32'(found), 32'd1);
    #2;
    rst[2] = 1'b1;
    #1;
    chk("c_rst_x",    2, 32'(px_all[2]),   32'd0);
    chk("c_rst_y",    2, 32'(py_all[2]),   32'd0);
    chk("c_rst_tick", 2, 32'(tick_all[2]), 32'd1);
    chk("c_rst_hs",   2, 32'(hs_all[2]),   32'd0);
    chk("c_rst_vs",   2, 32'(vs_all[2]),   32'd0);
    chk("c_rst_rgb",  2, 32'(rgb_all[2]),  32'd0);
    repeat (3) @(negedge clk);
    #2;
    rst[2] = 1'b0;
    found = 0;
    for (int k = 1; k <= 200 && found == 0; k++) begin
      @(posedge clk);
      #1;
      if (fs_all[2]) found = k + 1;
    end
    chk("c_frame_start_clks", 2, 32'(found), 32'd84);

    // Let the randomised runs cover several frame boundaries in every config.
    repeat (24000) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
